// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - central stall/flush controller for the five-stage pipeline
//
// Purpose: resolves load-use hazards, taken-branch redirects, I/D-cache miss
// stalls and the HLT drain sequence. It drives the enable/flush controls of
// the PC and of the four pipeline registers, and keeps saturating stall/flush
// performance counters.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_rs, id_rt                source registers of the instruction in ID
//   id_use_rs, id_use_rt        ID instruction actually reads rs / rt
//   ex_memread, ex_rd           EX instruction is a load, and its destination
//   branch_taken                branch resolved taken in ID
//   halt_id                     valid HLT in ID
//   icache_miss, dcache_miss    fetch / MEM access not ready (level)
//   pc_en .. mem_wb_en          register write enables and flushes
//   halted                      processor fully halted
//   stall_cnt, flush_cnt        saturating performance counters

module pipe_ctrl #(
    parameter int CNT_W = 16,
    parameter int DRAIN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_memread,
    input  logic [3:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             halt_id,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_HALTING = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    localparam logic [1:0] DRN_LAST = 2'(DRAIN - 1);

    state_t     state;
    logic [1:0] drn;
    logic       lu;

    // r0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign lu = ex_memread && (ex_rd != 4'd0) &&
                ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        halted      = 1'b0;
        if (rst || dcache_miss || (state == S_HALTED)) begin
            // Reset, a data-cache miss and the halted state all freeze every stage.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            halted    = !rst && (state == S_HALTED);
        end else if (state == S_HALTING) begin
            // Only bubbles follow the HLT down the pipe while it retires.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (branch_taken) begin
            // The redirect wins over a pending fetch miss: the fetched slot is discarded anyway.
            if_id_flush = 1'b1;
        end else if (halt_id) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
        end else if (icache_miss) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            drn       <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (!dcache_miss && !lu && !branch_taken && halt_id) begin
                        state <= S_HALTING;
                        drn   <= 2'd0;
                    end
                end
                S_HALTING: begin
                    // A data-cache miss holds the drain count: the HLT is frozen too.
                    if (!dcache_miss) begin
                        if (drn == DRN_LAST) begin
                            state <= S_HALTED;
                        end else begin
                            drn <= drn + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
            if ((state == S_RUN) && !pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the five-stage pipeline. It drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects, instruction- and data-cache miss stalls, and the HLT drain sequence. It also keeps saturating stall and flush performance counters.

## Interface
Parameters
- CNT_W, default 16: width of each performance counter.
- DRAIN, default 3: cycles needed to retire HLT once it has left ID (EX, MEM, WB).

Ports
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- id_rs, input, 4: source register 1 of the instruction in ID.
- id_rt, input, 4: source register 2 of the instruction in ID.
- id_use_rs, input, 1: ID instruction reads id_rs.
- id_use_rt, input, 1: ID instruction reads id_rt.
- ex_memread, input, 1: instruction in EX is a load.
- ex_rd, input, 4: destination register of the instruction in EX.
- branch_taken, input, 1: branch resolved taken in ID this cycle.
- halt_id, input, 1: valid HLT in ID.
- icache_miss, input, 1: fetch not ready this cycle (level).
- dcache_miss, input, 1: MEM-stage access not ready this cycle (level).
- pc_en, output, 1: PC write enable.
- if_id_en, output, 1: IF/ID write enable.
- if_id_flush, output, 1: IF/ID clear (bubble).
- id_ex_en, output, 1: ID/EX write enable.
- id_ex_flush, output, 1: ID/EX clear.
- ex_mem_en, output, 1: EX/MEM write enable.
- mem_wb_en, output, 1: MEM/WB write enable.
- halted, output, 1: processor fully halted.
- stall_cnt, output, CNT_W: cycles with pc_en=0 while in RUN.
- flush_cnt, output, CNT_W: cycles with if_id_flush=1.

## Operation
State machine, registered: RUN, HALTING, HALTED. A 2-bit drain counter `drn` counts the HLT retirement cycles.

Hazard terms, combinational:
- lu = ex_memread & ex_rd≠0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).

Default outputs: all enables 1, all flushes 0, halted 0.

RUN decode, first match wins:
1. dcache_miss: every enable is 0 and every flush is 0. The whole pipe freezes.
2. lu: pc_en=0 and if_id_en=0. id_ex_flush=1 inserts one bubble. branch_taken and halt_id are ignored this cycle; they are re-evaluated next cycle.
3. branch_taken: if_id_flush=1 and pc_en=1 (redirect). Any icache_miss is overridden.
4. halt_id: pc_en=0 and if_id_en=0. HLT advances into EX. On the edge, go to HALTING with drn=0.
5. icache_miss: pc_en=0 and if_id_flush=1. Downstream stages advance.

HALTING:
- pc_en=0, if_id_en=0, id_ex_flush=1 (bubbles follow HLT).
- EX/MEM and MEM/WB enables are 1, unless dcache_miss is high. In that case all enables are 0 and drn holds.
- Otherwise drn increments each cycle.
- When drn==DRAIN-1 and dcache_miss=0, go to HALTED.

HALTED:
- All enables 0, all flushes 0, halted=1.
- State is held until rst.

Counters:
- stall_cnt increments in RUN on any cycle with pc_en=0, for whatever reason.
- flush_cnt increments on any cycle with if_id_flush=1.
- Both counters saturate at all-ones and do not wrap.

## Timing
- All enable and flush outputs are combinational from the current state and inputs, valid within the same cycle. They take effect at the next edge.
- A load-use stall costs exactly 1 cycle. On the following cycle, lu is 0 because the load has moved to MEM.
- A taken branch costs 1 bubble.
- An icache miss costs N bubbles for N miss cycles.
- A dcache miss freezes the pipe for N cycles. On the first cycle with dcache_miss=0, normal decode resumes with no extra cycle.
- HLT in ID at cycle t:
  - HALTING during t+1 .. t+DRAIN.
  - halted=1 from t+DRAIN+1.
  - Every dcache_miss cycle during HALTING adds one cycle.
- While rst=1: all enables 0, flushes 0, halted 0. On the edge, state=RUN, drn=0, stall_cnt=0, flush_cnt=0.
- rst takes effect from any state, including mid-HALTING and mid-miss.

## Test plan
- Load-use stall: load r3 in EX, ID reads rs=3 with id_use_rs=1.
  - Required: pc_en=0, if_id_en=0, id_ex_flush=1 for 1 cycle, stall_cnt=1.
  - ex_rd=0: no stall.
- Priority, branch over icache_miss: branch_taken=1 with icache_miss=1.
  - Required: pc_en=1, if_id_flush=1, flush_cnt increments.
  - icache_miss alone for 3 cycles: 3 bubbles, stall_cnt=3.
- Priority, dcache_miss over lu and branch: dcache_miss=1 held 4 cycles together with lu=1 and branch_taken=1.
  - Required: all enables 0, flushes 0, for exactly 4 cycles.
  - Cycle 5: lu stall.
- HLT drain with miss: halt_id at cycle 10, dcache_miss=1 at cycle 12.
  - Required: halted=1 at cycle 15, not 14.
  - pc_en=0 from cycle 10 onward.
- Reset from halt: rst in HALTED.
  - Required: halted=0 during rst, counters 0, RUN with all enables 1 on the first idle cycle.
- Counter saturation: CNT_W=4, icache_miss held 20 cycles.
  - Required: stall_cnt=15 and flush_cnt=15, no wrap.
